// File: rtl/prog_load_ctrl.sv
// Mode sequencer for UART program loading: debounced start button, RUN/LOAD/HOLD FSM,
// loader/CPU reset control, ROM/RAM write steering, word counting and load timeout.
module prog_load_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned LOAD_TIMEOUT    = 2**26,
  parameter int unsigned RUN_HOLD        = 16
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        start_pg,
  input  logic        upg_wen_i,
  input  logic [14:0] upg_adr_i,
  input  logic        upg_done_i,
  output logic        upg_rst_o,
  output logic        cpu_rst_o,
  output logic        rom_wen_o,
  output logic        dmem_wen_o,
  output logic [13:0] rom_words_o,
  output logic [13:0] dmem_words_o,
  output logic [1:0]  mode_o,
  output logic        load_err_o
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned ToW   = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam int unsigned HoldW = (RUN_HOLD > 1) ? $clog2(RUN_HOLD) : 1;

  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DebW-1:0]  DebSat   = DebW'(DEBOUNCE_CYCLES);
  localparam logic [ToW-1:0]   ToLast   = ToW'(LOAD_TIMEOUT - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RUN_HOLD - 1);
  localparam logic [13:0]      WordMax  = 14'h3FFF;

  typedef enum logic [1:0] {
    StRun  = 2'b00,
    StLoad = 2'b01,
    StHold = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
  logic              start_pulse_q, start_pulse_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [ToW-1:0]    to_cnt_q, to_cnt_d;
  logic [13:0]       rom_cnt_q, rom_cnt_d;
  logic [13:0]       dmem_cnt_q, dmem_cnt_d;
  logic              load_err_q, load_err_d;
  logic              wr_rom, wr_dmem;

  // Only the RAM/ROM select bit of the address matters here.
  logic unused_adr;
  assign unused_adr = ^upg_adr_i[13:0];

  always_comb begin
    sync_d        = {sync_q[0], start_pg};
    deb_cnt_d     = deb_cnt_q;
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    to_cnt_d      = to_cnt_q;
    rom_cnt_d     = rom_cnt_q;
    dmem_cnt_d    = dmem_cnt_q;
    load_err_d    = load_err_q;

    // Counter parks one past the trigger value so a held button yields a single pulse.
    if (!sync_q[1]) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DebSat) begin
      deb_cnt_d = deb_cnt_q + DebW'(1);
    end
    start_pulse_d = sync_q[1] && (deb_cnt_q == DebLast);

    wr_rom  = (state_q == StLoad) && !rst && upg_wen_i && !upg_adr_i[14];
    wr_dmem = (state_q == StLoad) && !rst && upg_wen_i &&  upg_adr_i[14];

    case (state_q)
      StRun: begin
        if (start_pulse_q) begin
          state_d    = StLoad;
          to_cnt_d   = '0;
          rom_cnt_d  = '0;
          dmem_cnt_d = '0;
          load_err_d = 1'b0;
        end
      end
      StLoad: begin
        if (wr_rom && rom_cnt_q != WordMax) rom_cnt_d = rom_cnt_q + 14'd1;
        if (wr_dmem && dmem_cnt_q != WordMax) dmem_cnt_d = dmem_cnt_q + 14'd1;
        to_cnt_d = upg_wen_i ? '0 : to_cnt_q + ToW'(1);
        if (upg_done_i) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end else if (!upg_wen_i && to_cnt_q == ToLast) begin
          state_d    = StHold;
          hold_cnt_d = '0;
          load_err_d = 1'b1;
        end
      end
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d    = StRun;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      default: begin
        state_d    = StHold;
        hold_cnt_d = '0;
      end
    endcase

    rom_wen_o    = wr_rom;
    dmem_wen_o   = wr_dmem;
    upg_rst_o    = (state_q != StLoad);
    cpu_rst_o    = (state_q != StRun);
    mode_o       = state_q;
    rom_words_o  = rom_cnt_q;
    dmem_words_o = dmem_cnt_q;
    load_err_o   = load_err_q;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q       <= StHold;
      sync_q        <= '0;
      deb_cnt_q     <= '0;
      start_pulse_q <= 1'b0;
      hold_cnt_q    <= '0;
      to_cnt_q      <= '0;
      rom_cnt_q     <= '0;
      dmem_cnt_q    <= '0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      deb_cnt_q     <= deb_cnt_d;
      start_pulse_q <= start_pulse_d;
      hold_cnt_q    <= hold_cnt_d;
      to_cnt_q      <= to_cnt_d;
      rom_cnt_q     <= rom_cnt_d;
      dmem_cnt_q    <= dmem_cnt_d;
      load_err_q    <= load_err_d;
    end
  end

endmodule
